bsg_manycore_scratchpad_responder: RTL and testbench
====================================================

Name: bsg_manycore_scratchpad_responder

Overview:
- Target-side responder for remote requests issued by vanilla cores: loads, stores and atomics (swap, add, or).
- Sits behind a bsg_manycore_endpoint_standard rx interface in accelerator/scratchpad tiles.
- Serves requests from a 1RW synchronous word-addressed SRAM.
- Returns load data formatted per load_info, and acknowledges every accepted request.

Parameters:
- data_width_p, 32, word width; multiple of 8.
- addr_width_p, 28, endpoint word-address width.
- mem_els_p, 1024, SRAM words; mem_addr_width_lp = `BSG_SAFE_CLOG2(mem_els_p).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- in_v_i  in  1  request valid from endpoint
- in_we_i  in  1  1 = store, 0 = load/atomic
- in_addr_i  in  addr_width_p  word address
- in_data_i  in  data_width_p  store/atomic operand
- in_mask_i  in  data_width_p/8  store byte mask
- in_load_info_i  in  bsg_manycore_load_info_s  {float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0]}
- in_amo_v_i  in  1  request is atomic (valid only with in_we_i=0)
- in_amo_op_i  in  2  0 swap, 1 add, 2 or, 3 reserved (treated as swap)
- in_yumi_o  out  1  request consumed this cycle
- returning_v_o  out  1  response valid
- returning_data_o  out  data_width_p  load/atomic old value; 0 for stores
- err_o  out  1  one-cycle pulse on out-of-range access

Behaviour:
- Reset: state IDLE; in_yumi_o=0, returning_v_o=0, returning_data_o=0, err_o=0. SRAM contents are undefined. Reset mid-atomic abandons the write-back.
- Range check: in range iff in_addr_i[addr_width_p-1:mem_addr_width_lp]==0 and index < mem_els_p.
  - Out of range: request is still consumed and acknowledged; no SRAM write; returning_data_o=0; err_o pulses in the response cycle.
- States: IDLE, AMO_WB.
- IDLE:
  - in_yumi_o = in_v_i, combinational. No yumi without v.
  - Non-atomic request: SRAM access issued the same cycle; next state IDLE. A request can be accepted every cycle.
  - Store: byte-masked write.
  - Load: SRAM read.
  - Atomic: SRAM read; index, op and operand are registered; next state AMO_WB.
- AMO_WB:
  - in_yumi_o=0.
  - Write new = f(old, operand) to the SRAM: swap = operand; add = old+operand (mod 2^data_width_p); or = old|operand.
  - Next state IDLE. Atomic throughput is 1 per 2 cycles.
- Response:
  - returning_v_o is asserted exactly the cycle after every in_yumi_o, with no backpressure (endpoint contract).
  - returning_data_o is valid only while returning_v_o=1 and is held otherwise.
- Load formatting, applied to the SRAM read data in the response cycle using the registered load_info:
  - byte: byte[part_sel], sign- or zero-extended per is_unsigned_op.
  - hex: halfword[part_sel[1]], extended the same way.
  - otherwise: full word.
  - Atomics always return the full old word.
- Hazard: the atomic write-back occupies the SRAM port, so no request is accepted in AMO_WB; load-after-atomic ordering is preserved.
- Store followed by a load to the same address in the next cycle returns the stored data (SRAM write completes first).
- Simultaneous reset and in_v_i: reset wins; no yumi.

Test Plan:
- Store 0xDEADBEEF to addr 5, mask 4'b1111, then load addr 5 -> yumi in both cycles; returning_v_o the cycle after each; load returns 0xDEADBEEF, store returns 0.
- Load addr 5 with byte op, part_sel=3, signed -> 0xFFFFFFDE. Same with unsigned -> 0x000000DE. Hex op, part_sel=2, unsigned -> 0x0000DEAD.
- Store 0x000000AA to addr 5 with mask 4'b0001 -> subsequent load returns 0xDEADBEAA.
- amoadd operand 1 at addr 7 holding 0xFFFFFFFF, with a back-to-back load addr 7 queued -> amoadd returns 0xFFFFFFFF; in_yumi_o low for one cycle; then load returns 0x00000000 (wrap-around).
- Load at addr = mem_els_p -> consumed; returning_v_o next cycle with data 0; err_o pulses; SRAM unchanged.
- Assert reset_i in AMO_WB of an amoswap -> no write-back; outputs return to reset values next cycle; a fresh request is accepted afterwards.

Source files
------------

// File: rtl/bsg_manycore_scratchpad_responder.sv
// Target-side responder that serves remote loads, stores and atomics from a
// single-port synchronous SRAM, acknowledging every accepted request one cycle later.

package bsg_manycore_responder_pkg;
   typedef struct packed {
      logic       float_wb;
      logic       icache_fetch;
      logic       is_unsigned_op;
      logic       is_byte_op;
      logic       is_hex_op;
      logic [1:0] part_sel;
   } bsg_manycore_load_info_s;
endpackage

module bsg_manycore_scratchpad_responder
   import bsg_manycore_responder_pkg::*;
#(
   parameter  int data_width_p      = 32,
   parameter  int addr_width_p      = 28,
   parameter  int mem_els_p         = 1024,
   localparam int mem_addr_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1,
   localparam int mask_width_lp     = data_width_p / 8
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         in_v_i,
   input  logic                         in_we_i,
   input  logic [addr_width_p-1:0]      in_addr_i,
   input  logic [data_width_p-1:0]      in_data_i,
   input  logic [mask_width_lp-1:0]     in_mask_i,
   input  bsg_manycore_load_info_s      in_load_info_i,
   input  logic                         in_amo_v_i,
   input  logic [1:0]                   in_amo_op_i,
   output logic                         in_yumi_o,
   output logic                         returning_v_o,
   output logic [data_width_p-1:0]      returning_data_o,
   output logic                         err_o
);

   typedef enum logic {IDLE, AMO_WB} state_e;

   state_e state_r, state_n;

   logic [data_width_p-1:0]      sram [mem_els_p];
   logic [data_width_p-1:0]      sram_rdata_r;
   logic                         sram_w, sram_r;
   logic [mem_addr_width_lp-1:0] sram_idx;
   logic [data_width_p-1:0]      sram_wdata;
   logic [mask_width_lp-1:0]     sram_wmask;

   logic [mem_addr_width_lp-1:0] in_idx;
   logic                         in_range;

   logic [mem_addr_width_lp-1:0] amo_idx_r;
   logic [1:0]                   amo_op_r;
   logic [data_width_p-1:0]      amo_operand_r;
   logic                         amo_in_range_r;
   logic [data_width_p-1:0]      amo_new;

   logic                         resp_v_r, resp_zero_r, resp_err_r, resp_amo_r;
   logic                         resp_unsigned_r, resp_byte_r, resp_hex_r;
   logic [1:0]                   resp_part_sel_r;
   logic [data_width_p-1:0]      resp_data, hold_r;
   logic [7:0]                   byte_sel;
   logic [15:0]                  hex_sel;

   logic                         unused_load_info;

   assign unused_load_info = ^{in_load_info_i.float_wb, in_load_info_i.icache_fetch};

   assign in_idx   = in_addr_i[mem_addr_width_lp-1:0];
   assign in_range = ((in_addr_i >> mem_addr_width_lp) == '0)
                     && (32'(in_idx) < 32'(mem_els_p));

   always_comb begin
      case (amo_op_r)
         2'd1:    amo_new = sram_rdata_r + amo_operand_r;
         2'd2:    amo_new = sram_rdata_r | amo_operand_r;
         default: amo_new = amo_operand_r;
      endcase
   end

   // Next state and SRAM port control; the AMO write-back owns the port for a cycle.
   always_comb begin
      state_n    = state_r;
      in_yumi_o  = 1'b0;
      sram_w     = 1'b0;
      sram_r     = 1'b0;
      sram_idx   = in_idx;
      sram_wdata = in_data_i;
      sram_wmask = in_mask_i;
      case (state_r)
         IDLE: begin
            in_yumi_o = in_v_i & ~reset_i;
            if (in_yumi_o) begin
               if (in_we_i) begin
                  sram_w = in_range;
               end else begin
                  sram_r = in_range;
                  if (in_amo_v_i) state_n = AMO_WB;
               end
            end
         end
         AMO_WB: begin
            sram_w     = amo_in_range_r & ~reset_i;
            sram_idx   = amo_idx_r;
            sram_wdata = amo_new;
            sram_wmask = '1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (sram_w) begin
         for (int b = 0; b < mask_width_lp; b++) begin
            if (sram_wmask[b]) sram[sram_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
         end
      end
      if (sram_r) sram_rdata_r <= sram[sram_idx];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r         <= IDLE;
         resp_v_r        <= 1'b0;
         resp_zero_r     <= 1'b0;
         resp_err_r      <= 1'b0;
         resp_amo_r      <= 1'b0;
         resp_unsigned_r <= 1'b0;
         resp_byte_r     <= 1'b0;
         resp_hex_r      <= 1'b0;
         resp_part_sel_r <= 2'd0;
         amo_idx_r       <= '0;
         amo_op_r        <= 2'd0;
         amo_operand_r   <= '0;
         amo_in_range_r  <= 1'b0;
         hold_r          <= '0;
      end else begin
         state_r  <= state_n;
         resp_v_r <= in_yumi_o;
         if (in_yumi_o) begin
            resp_zero_r     <= in_we_i | ~in_range;
            resp_err_r      <= ~in_range;
            resp_amo_r      <= ~in_we_i & in_amo_v_i;
            resp_unsigned_r <= in_load_info_i.is_unsigned_op;
            resp_byte_r     <= in_load_info_i.is_byte_op;
            resp_hex_r      <= in_load_info_i.is_hex_op;
            resp_part_sel_r <= in_load_info_i.part_sel;
         end
         if (in_yumi_o & ~in_we_i & in_amo_v_i) begin
            amo_idx_r      <= in_idx;
            amo_op_r       <= in_amo_op_i;
            amo_operand_r  <= in_data_i;
            amo_in_range_r <= in_range;
         end
         if (resp_v_r) hold_r <= resp_data;
      end
   end

   // Sub-word loads are extracted from the registered SRAM word; atomics return it whole.
   always_comb begin
      byte_sel  = sram_rdata_r[8*resp_part_sel_r +: 8];
      hex_sel   = sram_rdata_r[16*resp_part_sel_r[1] +: 16];
      resp_data = sram_rdata_r;
      if (resp_zero_r) begin
         resp_data = '0;
      end else if (!resp_amo_r) begin
         if (resp_byte_r)
            resp_data = {{(data_width_p-8){~resp_unsigned_r & byte_sel[7]}}, byte_sel};
         else if (resp_hex_r)
            resp_data = {{(data_width_p-16){~resp_unsigned_r & hex_sel[15]}}, hex_sel};
      end
   end

   assign returning_v_o    = resp_v_r;
   assign returning_data_o = resp_v_r ? resp_data : hold_r;
   assign err_o            = resp_v_r & resp_err_r;

endmodule

// File: tb/tb_bsg_manycore_scratchpad_responder.sv
// Directed self-checking bench for the scratchpad responder: loads, stores,
// sub-word formatting, atomics, out-of-range accesses and reset during write-back.

module tb_bsg_manycore_scratchpad_responder;
   import bsg_manycore_responder_pkg::*;

   logic                    clk_i = 1'b0;
   logic                    reset_i;
   logic                    in_v_i, in_we_i, in_amo_v_i;
   logic [27:0]             in_addr_i;
   logic [31:0]             in_data_i;
   logic [3:0]              in_mask_i;
   bsg_manycore_load_info_s in_load_info_i;
   logic [1:0]              in_amo_op_i;
   logic                    in_yumi_o, returning_v_o, err_o;
   logic [31:0]             returning_data_o;

   int vector_count = 0;
   int miss_count   = 0;

   localparam logic [6:0] LI_WORD    = 7'b0000000;
   localparam logic [6:0] LI_BYTE_S3 = 7'b0001011;
   localparam logic [6:0] LI_BYTE_U3 = 7'b0011011;
   localparam logic [6:0] LI_HEX_U2  = 7'b0010110;
   localparam logic [6:0] LI_BYTE_U0 = 7'b0011000;
   localparam logic [6:0] LI_HEX_S0  = 7'b0000100;

   bsg_manycore_scratchpad_responder #(
      .data_width_p(32), .addr_width_p(28), .mem_els_p(1024)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .in_v_i(in_v_i), .in_we_i(in_we_i), .in_addr_i(in_addr_i),
      .in_data_i(in_data_i), .in_mask_i(in_mask_i),
      .in_load_info_i(in_load_info_i), .in_amo_v_i(in_amo_v_i),
      .in_amo_op_i(in_amo_op_i), .in_yumi_o(in_yumi_o),
      .returning_v_o(returning_v_o), .returning_data_o(returning_data_o),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vector_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic we, input logic [27:0] addr,
                                input logic [31:0] data, input logic [3:0] mask,
                                input logic [6:0] info, input logic amo,
                                input logic [1:0] op);
      in_v_i         = v;
      in_we_i        = we;
      in_addr_i      = addr;
      in_data_i      = data;
      in_mask_i      = mask;
      in_load_info_i = info;
      in_amo_v_i     = amo;
      in_amo_op_i    = op;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 28'd0, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkResp(input string tag, input logic [31:0] exp_data,
                            input logic exp_err);
      checkOutput({tag, " v"},    {31'd0, returning_v_o}, 32'd1);
      checkOutput({tag, " data"}, returning_data_o, exp_data);
      checkOutput({tag, " err"},  {31'd0, err_o}, {31'd0, exp_err});
   endtask

   task automatic singleReq(input string tag, input logic we, input logic [27:0] addr,
                            input logic [31:0] data, input logic [3:0] mask,
                            input logic [6:0] info, input logic amo, input logic [1:0] op,
                            input logic [31:0] exp_data, input logic exp_err);
      applyStimulus(1'b1, we, addr, data, mask, info, amo, op);
      #1;
      checkOutput({tag, " yumi"}, {31'd0, in_yumi_o}, 32'd1);
      tick();
      idle();
      checkResp(tag, exp_data, exp_err);
      if (amo) tick();
   endtask

   initial begin
      reset_i = 1'b1;
      applyStimulus(1'b1, 1'b0, 28'd5, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0);
      #1;
      checkOutput("reset yumi", {31'd0, in_yumi_o}, 32'd0);
      repeat (3) tick();
      checkOutput("reset v",    {31'd0, returning_v_o}, 32'd0);
      checkOutput("reset data", returning_data_o, 32'd0);
      checkOutput("reset err",  {31'd0, err_o}, 32'd0);
      reset_i = 1'b0;
      idle();
      tick();

      // Store then back-to-back load to the same word
      applyStimulus(1'b1, 1'b1, 28'd5, 32'hDEADBEEF, 4'b1111, LI_WORD, 1'b0, 2'd0);
      #1;
      checkOutput("st5 yumi", {31'd0, in_yumi_o}, 32'd1);
      tick();
      checkResp("st5", 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 28'd5, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0);
      #1;
      checkOutput("ld5 yumi", {31'd0, in_yumi_o}, 32'd1);
      tick();
      checkResp("ld5", 32'hDEADBEEF, 1'b0);
      idle();
      tick();
      checkOutput("idle v",    {31'd0, returning_v_o}, 32'd0);
      checkOutput("idle hold", returning_data_o, 32'hDEADBEEF);

      singleReq("ld byte s3", 1'b0, 28'd5, 32'd0, 4'd0, LI_BYTE_S3, 1'b0, 2'd0, 32'hFFFFFFDE, 1'b0);
      singleReq("ld byte u3", 1'b0, 28'd5, 32'd0, 4'd0, LI_BYTE_U3, 1'b0, 2'd0, 32'h000000DE, 1'b0);
      singleReq("ld hex u2",  1'b0, 28'd5, 32'd0, 4'd0, LI_HEX_U2,  1'b0, 2'd0, 32'h0000DEAD, 1'b0);
      singleReq("ld byte u0", 1'b0, 28'd5, 32'd0, 4'd0, LI_BYTE_U0, 1'b0, 2'd0, 32'h000000EF, 1'b0);
      singleReq("ld hex s0",  1'b0, 28'd5, 32'd0, 4'd0, LI_HEX_S0,  1'b0, 2'd0, 32'hFFFFBEEF, 1'b0);

      singleReq("st mask1",   1'b1, 28'd5, 32'h000000AA, 4'b0001, LI_WORD, 1'b0, 2'd0, 32'd0, 1'b0);
      singleReq("ld masked",  1'b0, 28'd5, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0, 32'hDEADBEAA, 1'b0);

      // amoadd with a queued load that must wait out the write-back cycle
      singleReq("st7", 1'b1, 28'd7, 32'hFFFFFFFF, 4'b1111, LI_WORD, 1'b0, 2'd0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 28'd7, 32'h00000001, 4'd0, LI_WORD, 1'b1, 2'd1);
      #1;
      checkOutput("amoadd yumi", {31'd0, in_yumi_o}, 32'd1);
      tick();
      checkResp("amoadd", 32'hFFFFFFFF, 1'b0);
      applyStimulus(1'b1, 1'b0, 28'd7, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0);
      #1;
      checkOutput("amo_wb yumi", {31'd0, in_yumi_o}, 32'd0);
      tick();
      checkOutput("amo_wb v", {31'd0, returning_v_o}, 32'd0);
      checkOutput("ld7 yumi", {31'd0, in_yumi_o}, 32'd1);
      tick();
      idle();
      checkResp("ld7 wrap", 32'h00000000, 1'b0);

      singleReq("amoor",   1'b0, 28'd7, 32'h000000F0, 4'd0, LI_WORD, 1'b1, 2'd2, 32'h00000000, 1'b0);
      singleReq("ld7 or",  1'b0, 28'd7, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0, 32'h000000F0, 1'b0);
      singleReq("amoswap", 1'b0, 28'd7, 32'h12345678, 4'd0, LI_WORD, 1'b1, 2'd0, 32'h000000F0, 1'b0);
      singleReq("ld7 swp", 1'b0, 28'd7, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0, 32'h12345678, 1'b0);
      singleReq("amo rsv", 1'b0, 28'd7, 32'h0BADF00D, 4'd0, LI_WORD, 1'b1, 2'd3, 32'h12345678, 1'b0);
      singleReq("ld7 rsv", 1'b0, 28'd7, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0, 32'h0BADF00D, 1'b0);

      // Out-of-range accesses are acknowledged, flagged and leave the SRAM alone
      singleReq("ld oor", 1'b0, 28'd1024, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0, 32'd0, 1'b1);
      tick();
      checkOutput("oor err end", {31'd0, err_o}, 32'd0);
      singleReq("st oor", 1'b1, 28'h405, 32'h11111111, 4'b1111, LI_WORD, 1'b0, 2'd0, 32'd0, 1'b1);
      singleReq("ld5 kept", 1'b0, 28'd5, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0, 32'hDEADBEAA, 1'b0);

      // Reset during the amoswap write-back must abandon the write
      singleReq("st9", 1'b1, 28'd9, 32'hCAFEF00D, 4'b1111, LI_WORD, 1'b0, 2'd0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 28'd9, 32'h55555555, 4'd0, LI_WORD, 1'b1, 2'd0);
      #1;
      checkOutput("swp9 yumi", {31'd0, in_yumi_o}, 32'd1);
      tick();
      checkResp("swp9", 32'hCAFEF00D, 1'b0);
      idle();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      checkOutput("rst amo v",    {31'd0, returning_v_o}, 32'd0);
      checkOutput("rst amo data", returning_data_o, 32'd0);
      checkOutput("rst amo err",  {31'd0, err_o}, 32'd0);
      singleReq("ld9 after rst", 1'b0, 28'd9, 32'd0, 4'd0, LI_WORD, 1'b0, 2'd0, 32'hCAFEF00D, 1'b0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
